mem_responder: RTL



---
 rtl/mem_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: one word request at a time over valid/ready, serviced
// from a word-addressed synchronous RAM or a small I/O window after wait states.
module mem_responder #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      ADDR_BITS   = 10,
    parameter int unsigned      WAIT_STATES = 1,
    parameter logic [WIDTH-1:0] IO_BASE     = 16'hFF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    input  logic [7:0]       sw_in,
    output logic [7:0]       led_out,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] IO_LED = IO_BASE;
    localparam logic [WIDTH-1:0] IO_SW  = IO_BASE + WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] IO_CNT = IO_BASE + WIDTH'(32'd2);
    localparam logic [3:0] WAIT_LOAD =
        (WAIT_STATES == 32'd0) ? 4'd0 : 4'(WAIT_STATES - 32'd1);

    state_t               state_r;
    logic                 we_r;
    logic [WIDTH-1:0]     addr_r;
    logic [WIDTH-1:0]     wdata_r;
    logic [3:0]           wcnt_r;
    logic                 req_ready_r;
    logic                 resp_valid_r;
    logic [WIDTH-1:0]     rdata_r;
    logic [7:0]           led_r;
    logic                 err_r;
    logic [WIDTH-1:0]     cyc_r;
    logic [7:0]           sw_meta_r;
    logic [7:0]           sw_sync_r;
    logic [WIDTH-1:0]     ram_r [0:(2**ADDR_BITS)-1];
    logic [WIDTH-1:0]     ram_q_r;

    logic [ADDR_BITS-1:0] rd_addr_s;
    logic                 is_ram_s;
    logic                 is_led_s;
    logic                 is_sw_s;
    logic                 is_cnt_s;
    logic                 mapped_s;
    logic [WIDTH-1:0]     rd_val_s;

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = rdata_r;
    assign led_out    = led_r;
    assign err        = err_r;

    // Address decode of the latched request and read-data selection.
    always_comb begin
        // In IDLE the RAM is pre-read at the incoming address so data is ready by ACCESS even with no wait states.
        rd_addr_s = (state_r == ST_IDLE) ? req_addr[ADDR_BITS-1:0] : addr_r[ADDR_BITS-1:0];
        is_ram_s  = (addr_r[WIDTH-1:ADDR_BITS] == {(WIDTH-ADDR_BITS){1'b0}});
        is_led_s  = (addr_r == IO_LED);
        is_sw_s   = (addr_r == IO_SW);
        is_cnt_s  = (addr_r == IO_CNT);
        mapped_s  = is_ram_s | is_led_s | is_sw_s | is_cnt_s;
        rd_val_s  = {WIDTH{1'b0}};
        if (is_ram_s) begin
            rd_val_s = ram_q_r;
        end else if (is_led_s) begin
            rd_val_s = {{(WIDTH-8){1'b0}}, led_r};
        end else if (is_sw_s) begin
            rd_val_s = {{(WIDTH-8){1'b0}}, sw_sync_r};
        end else if (is_cnt_s) begin
            rd_val_s = cyc_r;
        end else begin
            rd_val_s = {WIDTH{1'b0}};
        end
    end

    // Request FSM with registered handshake, response, LED and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            addr_r       <= {WIDTH{1'b0}};
            wdata_r      <= {WIDTH{1'b0}};
            wcnt_r       <= 4'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            rdata_r      <= {WIDTH{1'b0}};
            led_r        <= 8'd0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r        <= req_we;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        wcnt_r      <= WAIT_LOAD;
                        req_ready_r <= 1'b0;
                        state_r     <= (WAIT_STATES > 32'd0) ? ST_WAIT : ST_ACCESS;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_r == 4'd0) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        wcnt_r <= wcnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    rdata_r      <= we_r ? {WIDTH{1'b0}} : rd_val_s;
                    if (we_r && is_led_s) begin
                        led_r <= wdata_r[7:0];
                    end else begin
                        led_r <= led_r;
                    end
                    if (!mapped_s) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    rdata_r      <= {WIDTH{1'b0}};
                    req_ready_r  <= 1'b1;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    rdata_r      <= {WIDTH{1'b0}};
                    req_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Synchronous RAM: write commits at the end of ACCESS unless reset aborts it.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == ST_ACCESS) && we_r && is_ram_s) begin
            ram_r[addr_r[ADDR_BITS-1:0]] <= wdata_r;
        end
        ram_q_r <= ram_r[rd_addr_s];
    end

    // Free-running cycle counter and two-flop switch synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r     <= {WIDTH{1'b0}};
            sw_meta_r <= 8'd0;
            sw_sync_r <= 8'd0;
        end else begin
            cyc_r     <= cyc_r + WIDTH'(32'd1);
            sw_meta_r <= sw_in;
            sw_sync_r <= sw_meta_r;
        end
    end

endmodule
